// File: rtl/vram_readback_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vram_readback_pkg
// Purpose  : Shared types and constants for the VRAM readback UART dumper.
// Revision : 1.0 - initial release
// ============================================================================
package vram_readback_pkg;

   // Dump sequencer states
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_WAIT = 3'd2,
      S_LOAD = 3'd3,
      S_SEND = 3'd4,
      S_NEXT = 3'd5
   } state_e;

   // 115200 baud from a 10 MHz clock
   localparam int DEFAULT_CLKS_PER_BIT = 87;
   localparam int VRAM_ADDR_W          = 15;
   localparam int VRAM_LAST_ADDR       = 22499;

endpackage : vram_readback_pkg
`default_nettype wire

// File: rtl/vram_readback_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 serializer, LSB first. One byte per tx_start; tx_done pulses
//            in the last cycle of the stop bit.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx
   import vram_readback_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk10m,
   input  logic       rst_n,
   input  logic [7:0] data,
   input  logic       tx_start,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int              CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   c_CLK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      c_BIT_LAST = 4'd9;   // stop bit index

   logic [CW-1:0] clk_cnt_q, clk_cnt_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [8:0]    shift_q,   shift_d;    // remaining data bits plus stop bit
   logic          tx_q,      tx_d;
   logic          busy_q,    busy_d;
   logic          w_bit_end;

   assign w_bit_end = busy_q && (clk_cnt_q == c_CLK_LAST);
   assign tx_done   = w_bit_end && (bit_cnt_q == c_BIT_LAST);
   assign tx        = tx_q;
   assign tx_busy   = busy_q;

   // Next-state: load a frame when idle, advance one bit per CLKS_PER_BIT cycles
   always_comb begin
      clk_cnt_d = clk_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      if (!busy_q) begin
         if (tx_start) begin
            busy_d    = 1'b1;
            tx_d      = 1'b0;
            shift_d   = {1'b1, data};
            clk_cnt_d = '0;
            bit_cnt_d = '0;
         end
      end else if (w_bit_end) begin
         clk_cnt_d = '0;
         if (bit_cnt_q == c_BIT_LAST) begin
            busy_d = 1'b0;
            tx_d   = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
         end
      end else begin
         clk_cnt_d = clk_cnt_q + CW'(1);
      end
   end

   // Serializer registers; line forced idle-high the moment reset asserts
   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '1;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         clk_cnt_q <= clk_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

endmodule : uart_tx
`default_nettype wire

// File: rtl/vram_readback.sv
`default_nettype none
// ============================================================================
// Module   : vram_readback
// Purpose  : Streams a VRAM address range (with wrap at LAST_ADDR) out of a
//            UART, one byte per 8N1 frame, with start/abort control.
// Revision : 1.0 - initial release
// ============================================================================
module vram_readback
   import vram_readback_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int ADDR_W       = VRAM_ADDR_W,
   parameter int LAST_ADDR    = VRAM_LAST_ADDR
) (
   input  logic              clk10m,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [ADDR_W-1:0] end_addr,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_re,
   input  logic [7:0]        vram_data,
   output logic              uart_tx,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(LAST_ADDR);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cur_q,   cur_d;
   logic [ADDR_W-1:0] last_q,  last_d;
   logic [7:0]        byte_q,  byte_d;
   logic              abort_pend_q, abort_pend_d;
   logic              w_start_ok;
   logic              w_abort;
   logic              w_tx_start;
   logic              w_tx_busy;
   logic              w_tx_done;

   // Out-of-range addresses and a simultaneous abort both veto a start
   assign w_start_ok = start && !abort && (start_addr <= c_LAST) && (end_addr <= c_LAST);
   assign w_abort    = abort || abort_pend_q;

   // cur only changes on entry to READ, so it doubles as the held read address
   assign vram_addr  = cur_q;
   assign busy       = (state_q != S_IDLE);

   // Sequencer next-state and strobes
   always_comb begin
      state_d    = state_q;
      cur_d      = cur_q;
      last_d     = last_q;
      byte_d     = byte_q;
      vram_re    = 1'b0;
      done       = 1'b0;
      w_tx_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (w_start_ok) begin
               cur_d   = start_addr;
               last_d  = end_addr;
               state_d = S_READ;
            end
         end
         S_READ: begin
            vram_re = 1'b1;
            state_d = w_abort ? S_IDLE : S_WAIT;
         end
         S_WAIT: begin
            byte_d  = vram_data;
            state_d = w_abort ? S_IDLE : S_LOAD;
         end
         S_LOAD: begin
            // serializer is always free here; the check just keeps the handshake honest
            if (!w_tx_busy) begin
               w_tx_start = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (w_tx_done) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (w_abort) begin
               state_d = S_IDLE;
            end else if (cur_q == last_q) begin
               done    = 1'b1;
               state_d = S_IDLE;
            end else begin
               cur_d   = (cur_q == c_LAST) ? '0 : cur_q + ADDR_W'(1);
               state_d = S_READ;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // an abort seen while busy is remembered until the sequencer parks in IDLE
      abort_pend_d = (state_q != S_IDLE) && w_abort && (state_d != S_IDLE);
   end

   // Sequencer registers
   always_ff @(posedge clk10m or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         cur_q        <= '0;
         last_q       <= '0;
         byte_q       <= '0;
         abort_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         last_q       <= last_d;
         byte_q       <= byte_d;
         abort_pend_q <= abort_pend_d;
      end
   end

   uart_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk10m   (clk10m),
      .rst_n    (rst_n),
      .data     (byte_q),
      .tx_start (w_tx_start),
      .tx       (uart_tx),
      .tx_busy  (w_tx_busy),
      .tx_done  (w_tx_done)
   );

endmodule : vram_readback
`default_nettype wire

// File: tb/tb_vram_readback.sv
`default_nettype none
// ============================================================================
// Module   : tb_vram_readback
// Purpose  : Table-driven bench for vram_readback with a registered VRAM
//            model and a cycle-exact UART frame decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vram_readback;

   localparam int CPB  = 4;
   localparam int AW   = 15;
   localparam int LAST = 22499;
   localparam int FLEN = 10 * CPB;

   logic          clk10m = 1'b0;
   logic          rst_n;
   logic          start;
   logic          abort;
   logic [AW-1:0] start_addr;
   logic [AW-1:0] end_addr;
   logic [AW-1:0] vram_addr;
   logic          vram_re;
   logic [7:0]    vram_data = 8'h00;
   logic          uart_tx;
   logic          busy;
   logic          done;

   vram_readback #(
      .CLKS_PER_BIT (CPB),
      .ADDR_W       (AW),
      .LAST_ADDR    (LAST)
   ) dut (
      .clk10m     (clk10m),
      .rst_n      (rst_n),
      .start      (start),
      .abort      (abort),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .vram_addr  (vram_addr),
      .vram_re    (vram_re),
      .vram_data  (vram_data),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk10m = ~clk10m;

   // VRAM model with one-cycle registered read latency
   logic [7:0] mem [0:LAST];
   always @(posedge clk10m) begin
      if (vram_re) vram_data <= mem[int'(vram_addr)];
   end

   // Monitor and UART decoder, sampled on the falling edge
   int             cyc = 0;
   int             fs_cnt = 0;
   int             shape_bad = 0;
   int             done_cnt = 0;
   int             done_cyc = -1;
   int             busy_fall_cyc = -1;
   int             busy_hi = 0;
   bit             in_frame = 1'b0;
   bit             prev_busy = 1'b0;
   int             fidx = 0;
   int             cur_start = 0;
   logic [FLEN-1:0] fbits;
   logic [AW-1:0]  re_addr [$];
   logic [9:0]     rx_bits [$];
   int             rx_start [$];

   always @(negedge clk10m) begin
      logic [9:0] v10;
      bit         bad;
      cyc = cyc + 1;
      if (vram_re) re_addr.push_back(vram_addr);
      if (done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
      if (prev_busy && !busy) busy_fall_cyc = cyc;
      if (busy) busy_hi = busy_hi + 1;
      prev_busy = busy;
      if (!rst_n) begin
         in_frame = 1'b0;
      end else if (in_frame || (uart_tx == 1'b0)) begin
         if (!in_frame) begin
            in_frame  = 1'b1;
            fidx      = 0;
            fs_cnt    = fs_cnt + 1;
            cur_start = cyc;
         end
         fbits[fidx] = uart_tx;
         fidx = fidx + 1;
         if (fidx == FLEN) begin
            in_frame = 1'b0;
            bad = 1'b0;
            for (int k = 0; k < 10; k++) begin
               v10[k] = fbits[k*CPB];
               for (int j = 0; j < CPB; j++)
                  if (fbits[k*CPB+j] !== fbits[k*CPB]) bad = 1'b1;
            end
            if (v10[0] !== 1'b0 || v10[9] !== 1'b1) bad = 1'b1;
            if (bad) shape_bad = shape_bad + 1;
            rx_bits.push_back(v10);
            rx_start.push_back(cur_start);
         end
      end
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk = n_chk + 1;
      if (act != exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic do_start(input int sa, input int ea, input bit ab);
      @(posedge clk10m); #1;
      start_addr = AW'(sa);
      end_addr   = AW'(ea);
      start      = 1'b1;
      abort      = ab;
      @(posedge clk10m); #1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20000; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk10m); #1;
      end
   endtask

   task automatic wait_fs(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         if (fs_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk10m); #1;
      end
   endtask

   function automatic int wrap_addr(input int a);
      return (a > LAST) ? a - (LAST + 1) : a;
   endfunction

   // One dump request with full checking of what comes out
   task automatic run_entry(input int sa, input int ea, input bit ab, input bit acc);
      int b_re, b_rx, b_done, b_shape, b_hi, n, a, m;
      bit ok;
      b_re = re_addr.size(); b_rx = rx_bits.size(); b_done = done_cnt;
      b_shape = shape_bad; b_hi = busy_hi;
      do_start(sa, ea, ab);
      chk("busy_after_start", busy, acc);
      if (!acc) begin
         repeat (4) @(posedge clk10m);
         #1;
         chk("rejected_busy_cycles", busy_hi - b_hi, 0);
         chk("rejected_vram_re", re_addr.size() - b_re, 0);
      end else begin
         n = (ea >= sa) ? ea - sa + 1 : (LAST - sa + 1) + ea + 1;
         wait_idle(ok);
         chk("dump_timeout", ok, 1);
         repeat (2) @(posedge clk10m);
         #1;
         chk("vram_re_count", re_addr.size() - b_re, n);
         chk("frame_count", rx_bits.size() - b_rx, n);
         chk("done_pulses", done_cnt - b_done, 1);
         chk("frame_shape_errors", shape_bad - b_shape, 0);
         chk("busy_fall_after_done", busy_fall_cyc, done_cyc + 1);
         m = re_addr.size() - b_re;
         if (m > n) m = n;
         for (int i = 0; i < m; i++)
            chk("vram_addr_seq", re_addr[b_re+i], wrap_addr(sa + i));
         m = rx_bits.size() - b_rx;
         if (m > n) m = n;
         for (int i = 0; i < m; i++) begin
            a = wrap_addr(sa + i);
            chk("frame_bits", rx_bits[b_rx+i], {1'b1, mem[a], 1'b0});
            if (i > 0)
               chk("frame_spacing", rx_start[b_rx+i] - rx_start[b_rx+i-1], FLEN + 4);
         end
         if (sa == 5 && ea == 5 && m > 0)
            chk("single_A5_bit_sequence", rx_bits[b_rx], 10'b1101001010);
      end
   endtask

   typedef struct {
      int sa;
      int ea;
      bit ab;
      bit acc;
   } vec_t;

   vec_t tbl [7];

   initial begin
      int  b_re, b_rx, b_done, b_shape, b_fs;
      bit  ok;

      tbl[0] = '{sa: 10,    ea: 12,    ab: 1'b0, acc: 1'b1};
      tbl[1] = '{sa: 22498, ea: 1,     ab: 1'b0, acc: 1'b1};
      tbl[2] = '{sa: 5,     ea: 5,     ab: 1'b0, acc: 1'b1};
      tbl[3] = '{sa: 30000, ea: 5,     ab: 1'b0, acc: 1'b0};
      tbl[4] = '{sa: 5,     ea: 22500, ab: 1'b0, acc: 1'b0};
      tbl[5] = '{sa: 20,    ea: 22,    ab: 1'b1, acc: 1'b0};
      tbl[6] = '{sa: 1000,  ea: 1001,  ab: 1'b0, acc: 1'b1};

      for (int i = 0; i <= LAST; i++) mem[i] = 8'((i * 37 + 11) & 255);
      mem[5]  = 8'hA5;
      mem[10] = 8'h41;
      mem[11] = 8'h42;
      mem[12] = 8'h43;

      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      start_addr = '0; end_addr = '0;
      repeat (3) @(posedge clk10m);
      #1;
      chk("reset_uart_tx", uart_tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_vram_re", vram_re, 0);
      chk("reset_vram_addr", vram_addr, 0);
      #2 rst_n = 1'b1;
      repeat (2) @(posedge clk10m);

      for (int t = 0; t < 7; t++)
         run_entry(tbl[t].sa, tbl[t].ea, tbl[t].ab, tbl[t].acc);

      // start while busy is ignored: the original range still completes
      b_re = re_addr.size(); b_rx = rx_bits.size();
      do_start(400, 401, 1'b0);
      repeat (3) @(posedge clk10m);
      #1;
      start_addr = AW'(900); end_addr = AW'(905); start = 1'b1;
      @(posedge clk10m); #1;
      start = 1'b0;
      wait_idle(ok);
      chk("busy_start_timeout", ok, 1);
      repeat (2) @(posedge clk10m);
      #1;
      chk("busy_start_re_count", re_addr.size() - b_re, 2);
      chk("busy_start_frames", rx_bits.size() - b_rx, 2);

      // abort during bit 3 of frame 2 of a 5-byte dump
      b_re = re_addr.size(); b_rx = rx_bits.size(); b_done = done_cnt;
      b_shape = shape_bad; b_fs = fs_cnt;
      do_start(200, 204, 1'b0);
      wait_fs(b_fs + 2, ok);
      chk("abort_frame2_timeout", ok, 1);
      repeat (3 * CPB) @(posedge clk10m);
      #1 abort = 1'b1;
      @(posedge clk10m); #1;
      abort = 1'b0;
      wait_idle(ok);
      chk("abort_idle_timeout", ok, 1);
      repeat (CPB * 12) @(posedge clk10m);
      #1;
      chk("abort_vram_re_count", re_addr.size() - b_re, 2);
      chk("abort_frame_count", rx_bits.size() - b_rx, 2);
      chk("abort_no_done", done_cnt - b_done, 0);
      chk("abort_shape_errors", shape_bad - b_shape, 0);
      chk("abort_busy", busy, 0);
      if (rx_bits.size() - b_rx >= 2) begin
         chk("abort_frame1", rx_bits[b_rx],   {1'b1, mem[200], 1'b0});
         chk("abort_frame2", rx_bits[b_rx+1], {1'b1, mem[201], 1'b0});
      end

      // asynchronous reset mid-frame, then a clean dump
      b_fs = fs_cnt;
      do_start(300, 302, 1'b0);
      wait_fs(b_fs + 1, ok);
      chk("reset_frame_timeout", ok, 1);
      repeat (5 * CPB) @(posedge clk10m);
      #3 rst_n = 1'b0;
      #1;
      chk("midframe_reset_uart_tx", uart_tx, 1);
      chk("midframe_reset_busy", busy, 0);
      chk("midframe_reset_vram_re", vram_re, 0);
      repeat (2) @(posedge clk10m);
      #2 rst_n = 1'b1;
      repeat (3) @(posedge clk10m);
      #1;
      chk("post_reset_idle_tx", uart_tx, 1);
      run_entry(10, 12, 1'b0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule : tb_vram_readback
`default_nettype wire
